// File: rtl/queue_gate_sensor.sv
// queue_gate_sensor
// Decodes the order in which the two queue-gate photo-beams are broken into
// single-cycle increment/decrement pulses for the queue counter. Each raw beam
// is synchronised (2 FF) and debounced; a sequence FSM accepts only complete
// passes, rejects partial ones and abandons stalled ones after a timeout.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high; clears all state
//   sens_front raw front (street side) beam, 1 = blocked, asynchronous
//   sens_back  raw back (hall side) beam, 1 = blocked, asynchronous
//   inc_pulse  one-cycle pulse: one person entered
//   dec_pulse  one-cycle pulse: one person left
//   busy       FSM not idle
//   seq_error  high while waiting for both beams to clear
//   front_db   debounced front beam
//   back_db    debounced back beam
module queue_gate_sensor #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic sens_front,
  input  logic sens_back,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic busy,
  output logic seq_error,
  output logic front_db,
  output logic back_db
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, E1, E2, E3, X1, X2, X3, WAIT_CLEAR
  } state_t;

  // Bit 1 = front beam, bit 0 = back beam, so db matches the FSM input order.
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic            active;
  logic            inc_next;
  logic            dec_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      db        <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1 <= {sens_front, sens_back};
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign front_db = db[1];
  assign back_db  = db[0];

  assign active = (state != IDLE) && (state != WAIT_CLEAR);

  always_comb begin
    state_next = state;
    inc_next   = 1'b0;
    dec_next   = 1'b0;
    unique case (state)
      IDLE: begin
        case (db)
          2'b10:   state_next = E1;
          2'b01:   state_next = X1;
          2'b11:   state_next = WAIT_CLEAR;
          default: ;
        endcase
      end
      E1: begin
        case (db)
          2'b11:   state_next = E2;
          2'b00:   state_next = IDLE;
          2'b01:   state_next = WAIT_CLEAR;
          default: ;
        endcase
      end
      E2: begin
        case (db)
          2'b01:   state_next = E3;
          2'b10:   state_next = E1;
          2'b00:   state_next = IDLE;
          default: ;
        endcase
      end
      E3: begin
        case (db)
          2'b00: begin
            state_next = IDLE;
            inc_next   = 1'b1;
          end
          2'b11:   state_next = E2;
          2'b10:   state_next = WAIT_CLEAR;
          default: ;
        endcase
      end
      X1: begin
        case (db)
          2'b11:   state_next = X2;
          2'b00:   state_next = IDLE;
          2'b10:   state_next = WAIT_CLEAR;
          default: ;
        endcase
      end
      X2: begin
        case (db)
          2'b10:   state_next = X3;
          2'b01:   state_next = X1;
          2'b00:   state_next = IDLE;
          default: ;
        endcase
      end
      X3: begin
        case (db)
          2'b00: begin
            state_next = IDLE;
            dec_next   = 1'b1;
          end
          2'b11:   state_next = X2;
          2'b01:   state_next = WAIT_CLEAR;
          default: ;
        endcase
      end
      WAIT_CLEAR: begin
        if (db == 2'b00) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A stalled pass is abandoned even if the beams change in the same cycle.
    if (active && (to_cnt == TO_LAST)) begin
      state_next = WAIT_CLEAR;
      inc_next   = 1'b0;
      dec_next   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      to_cnt    <= '0;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      state     <= state_next;
      inc_pulse <= inc_next;
      dec_pulse <= dec_next;
      if (!active || (state_next != state)) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign seq_error = (state == WAIT_CLEAR);

endmodule

// File: tb/tb_queue_gate_sensor.sv
// tb_queue_gate_sensor
// Directed stimulus for queue_gate_sensor. The stimulus process queues the
// pulses and status levels it expects (with the cycle they are due); a
// separate monitor process compares them against the DUT on falling edges.
module tb_queue_gate_sensor;

  logic clk = 1'b0;
  logic reset;
  logic sens_front;
  logic sens_back;
  logic inc_pulse;
  logic dec_pulse;
  logic busy;
  logic seq_error;
  logic front_db;
  logic back_db;

  typedef struct {
    int unsigned cyc;
    bit          is_inc;
  } pulse_t;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  val;   // {busy, seq_error, front_db, back_db}
  } level_t;

  pulse_t      pulse_q[$];
  level_t      level_q[$];
  int unsigned cyc = 0;
  bit          done = 1'b0;
  int          inc_exp = 0;
  int          dec_exp = 0;

  int          errors = 0;
  int          checks = 0;

  queue_gate_sensor #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sens_front(sens_front),
    .sens_back (sens_back),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .busy      (busy),
    .seq_error (seq_error),
    .front_db  (front_db),
    .back_db   (back_db)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Final raw release: pulse due 2 sync + 4 debounce + 1 register edges later.
  task automatic expect_pulse(input bit is_inc);
    pulse_t p;
    p.cyc    = cyc + 7;
    p.is_inc = is_inc;
    pulse_q.push_back(p);
    if (is_inc) inc_exp++;
    else        dec_exp++;
  endtask

  task automatic expect_level(input logic [3:0] val);
    level_t l;
    l.cyc = cyc;
    l.val = val;
    level_q.push_back(l);
  endtask

  task automatic drive(input logic f, input logic b);
    sens_front = f;
    sens_back  = b;
  endtask

  // Stimulus
  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0);
    tick(3);
    reset = 1'b0;
    expect_level(4'b0000);
    tick(5);

    // Clean entry
    drive(1, 0); tick(20);
    expect_level(4'b1010);
    drive(1, 1); tick(20);
    expect_level(4'b1011);
    drive(0, 1); tick(20);
    expect_level(4'b1001);
    drive(0, 0); expect_pulse(1'b1); tick(20);
    expect_level(4'b0000);

    // Clean exit
    drive(0, 1); tick(20);
    drive(1, 1); tick(20);
    drive(1, 0); tick(20);
    drive(0, 0); expect_pulse(1'b0); tick(20);
    expect_level(4'b0000);

    // Entry with back-off
    drive(1, 0); tick(20);
    drive(1, 1); tick(20);
    drive(1, 0); tick(20);
    expect_level(4'b1010);
    drive(1, 1); tick(20);
    drive(0, 1); tick(20);
    drive(0, 0); expect_pulse(1'b1); tick(20);

    // Abort
    drive(1, 0); tick(20);
    expect_level(4'b1010);
    drive(0, 0); tick(20);
    expect_level(4'b0000);

    // 3-cycle glitch on back beam in IDLE
    drive(0, 1); tick(3);
    drive(0, 0);
    for (int i = 0; i < 10; i++) begin
      expect_level(4'b0000);
      tick(1);
    end

    // Both beams together from idle
    drive(1, 1); tick(20);
    expect_level(4'b1111);
    drive(0, 1); tick(20);
    expect_level(4'b1101);
    drive(0, 0); tick(20);
    expect_level(4'b0000);

    // Timeout: front held for 200 cycles
    drive(1, 0); tick(20);
    expect_level(4'b1010);
    tick(80);
    expect_level(4'b1110);
    tick(100);
    expect_level(4'b1110);
    drive(0, 0); tick(20);
    expect_level(4'b0000);

    // Reset mid-pass while in E3
    drive(1, 0); tick(20);
    drive(1, 1); tick(20);
    drive(0, 1); tick(20);
    expect_level(4'b1001);
    reset = 1'b1; tick(1);
    reset = 1'b0;
    expect_level(4'b0000);
    tick(20);
    expect_level(4'b1001);
    drive(0, 0); tick(20);
    expect_level(4'b0000);

    // Throughput: ten entries then ten exits
    for (int i = 0; i < 10; i++) begin
      drive(1, 0); tick(8);
      drive(1, 1); tick(8);
      drive(0, 1); tick(8);
      drive(0, 0); expect_pulse(1'b1); tick(8);
    end
    for (int i = 0; i < 10; i++) begin
      drive(0, 1); tick(8);
      drive(1, 1); tick(8);
      drive(1, 0); tick(8);
      drive(0, 0); expect_pulse(1'b0); tick(8);
    end
    tick(20);
    expect_level(4'b0000);
    tick(2);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    int     inc_seen;
    int     dec_seen;
    pulse_t p;
    level_t l;
    logic [3:0] act;
    inc_seen = 0;
    dec_seen = 0;
    while (!done) begin
      @(negedge clk);
      act = {busy, seq_error, front_db, back_db};
      while (level_q.size() > 0 && level_q[0].cyc <= cyc) begin
        l = level_q.pop_front();
        checks++;
        if (l.cyc != cyc || act !== l.val) begin
          errors++;
          $display("FAIL level@%0d: got busy/seq/fdb/bdb=%b (cycle %0d), required %b",
                   l.cyc, act, cyc, l.val);
        end
      end
      if (inc_pulse === 1'b1 && dec_pulse === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL overlap@%0d: inc_pulse and dec_pulse both 1, required at most one", cyc);
      end
      for (int k = 0; k < 2; k++) begin
        bit seen;
        seen = (k == 0) ? (inc_pulse === 1'b1) : (dec_pulse === 1'b1);
        if (seen) begin
          if (k == 0) inc_seen++;
          else        dec_seen++;
          checks++;
          if (pulse_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s@%0d: got pulse, required none",
                     (k == 0) ? "inc" : "dec", cyc);
          end else begin
            p = pulse_q.pop_front();
            if (p.cyc != cyc || p.is_inc != (k == 0)) begin
              errors++;
              $display("FAIL pulse@%0d: got %s at cycle %0d, required %s at cycle %0d",
                       cyc, (k == 0) ? "inc" : "dec", cyc,
                       p.is_inc ? "inc" : "dec", p.cyc);
            end
          end
        end
      end
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        p = pulse_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_%s: got no pulse by cycle %0d, required at cycle %0d",
                 p.is_inc ? "inc" : "dec", cyc, p.cyc);
      end
    end

    while (pulse_q.size() > 0) begin
      p = pulse_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_%s_end: got no pulse, required at cycle %0d",
               p.is_inc ? "inc" : "dec", p.cyc);
    end
    while (level_q.size() > 0) begin
      l = level_q.pop_front();
      checks++;
      errors++;
      $display("FAIL level_unchecked@%0d: got no sample, required %b", l.cyc, l.val);
    end
    checks++;
    if (inc_seen != inc_exp) begin
      errors++;
      $display("FAIL inc_total: got %0d, required %0d", inc_seen, inc_exp);
    end
    checks++;
    if (dec_seen != dec_exp) begin
      errors++;
      $display("FAIL dec_total: got %0d, required %0d", dec_seen, dec_exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
